// File: rtl/mcht_pkg.sv
// Shared types and constants for the Manchester receiver: FSM states,
// abort-cause codes and the idle line level.
package mcht_pkg;

  typedef enum logic [2:0] {
    eHUNT,
    eIDLE,
    ePRE0,
    ePRE1,
    eH0,
    eH1,
    eSTOP
  } state_t;

  localparam logic [1:0] eERR_PRE  = 2'b01;
  localparam logic [1:0] eERR_CODE = 2'b10;
  localparam logic [1:0] eERR_STOP = 2'b11;

  localparam logic LINE_IDLE = 1'b1;

  function automatic logic is_busy(input state_t s);
    return (s == ePRE0) || (s == ePRE1) || (s == eH0) || (s == eH1) || (s == eSTOP);
  endfunction

  // Only these three states can abort a frame, so the cause follows from the state.
  function automatic logic [1:0] err_cause(input state_t s);
    case (s)
      ePRE1:   return eERR_PRE;
      eH1:     return eERR_CODE;
      default: return eERR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/mcht_sync.sv
// RXD synchronizer: pSYNC_STG flops reset to the idle level, pSYNC_STG cycles latency.
// Zero stages is a plain wire for a line already in the CLK_25M domain; no backpressure.
module mcht_sync #(
  parameter int pSYNC_STG = 2
) (
  input  logic CLK_25M,
  input  logic RST_N,
  input  logic rxd_i,
  output logic rxd_o
);

  generate
    if (pSYNC_STG == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = CLK_25M ^ RST_N;
      assign rxd_o = rxd_i;
    end else begin : g_flops
      logic [pSYNC_STG-1:0] sync_q;

      always_ff @(posedge CLK_25M or negedge RST_N) begin
        if (!RST_N) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= rxd_i;
          for (int i = 1; i < pSYNC_STG; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign rxd_o = sync_q[pSYNC_STG-1];
    end
  endgenerate

endmodule

// File: rtl/mcht_dec.sv
// Manchester frame receiver: word or typed error pulse one cycle after the stop sample
// (plus pSYNC_STG); the line cannot be stalled, so the consumer must take every pulse.
module mcht_dec
  import mcht_pkg::*;
#(
  parameter int pMSG_LEN  = 8,
  parameter int pHALF_CYC = 1,
  parameter int pSYNC_STG = 2
) (
  input  logic                CLK_25M,
  input  logic                RST_N,
  input  logic                RXD,
  output logic [pMSG_LEN-1:0] MSG,
  output logic                MSG_VLD,
  output logic                ERR,
  output logic [1:0]          ERR_TYPE,
  output logic                BUSY
);

  localparam int HW = (pHALF_CYC > 1) ? $clog2(pHALF_CYC) : 1;
  localparam int IW = (pMSG_LEN > 1) ? $clog2(pMSG_LEN) : 1;
  localparam logic [HW-1:0] HC_SAMP  = HW'(pHALF_CYC / 2);
  localparam logic [HW-1:0] HC_LAST  = HW'(pHALF_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(pMSG_LEN - 1);

  logic                rxd_s;
  state_t              state_q, state_d;
  logic [HW-1:0]       hcnt_q, hcnt_d;
  logic [IW-1:0]       idx_q;
  logic                h0_q;
  logic [pMSG_LEN-1:0] sr_q;
  logic [pMSG_LEN-1:0] msg_q;
  logic                msg_vld_q;
  logic                err_q;
  logic [1:0]          err_type_q;
  logic                busy_q;
  logic                sample;
  logic                adv;

  mcht_sync #(.pSYNC_STG(pSYNC_STG)) u_sync (
    .CLK_25M (CLK_25M),
    .RST_N   (RST_N),
    .rxd_i   (RXD),
    .rxd_o   (rxd_s)
  );

  assign sample = (hcnt_q == HC_SAMP);
  assign adv    = (hcnt_q == HC_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      eHUNT: if (rxd_s == LINE_IDLE) state_d = eIDLE;
      // The falling-edge cycle is already half-cycle 0 of the preamble low.
      eIDLE: if (rxd_s != LINE_IDLE) state_d = (pHALF_CYC == 1) ? ePRE1 : ePRE0;
      ePRE0: begin
        if (sample && rxd_s == LINE_IDLE) state_d = eIDLE;
        else if (adv)                     state_d = ePRE1;
      end
      ePRE1: begin
        if (sample && rxd_s != LINE_IDLE) state_d = eHUNT;
        else if (adv)                     state_d = eH0;
      end
      eH0:   if (adv) state_d = eH1;
      eH1: begin
        if (sample && rxd_s == h0_q) state_d = eHUNT;
        else if (adv)                state_d = (idx_q == IDX_LAST) ? eSTOP : eH0;
      end
      eSTOP: if (sample) state_d = (rxd_s == LINE_IDLE) ? eIDLE : eHUNT;
      default: state_d = eHUNT;
    endcase
  end

  always_comb begin
    if (state_q == eIDLE && state_d == ePRE0)       hcnt_d = HW'(1);
    else if (state_d != state_q || !is_busy(state_q)) hcnt_d = '0;
    else                                              hcnt_d = hcnt_q + HW'(1);
  end

  always_ff @(posedge CLK_25M or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= eHUNT;
      hcnt_q     <= '0;
      idx_q      <= '0;
      h0_q       <= 1'b0;
      sr_q       <= '0;
      msg_q      <= '0;
      msg_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      err_type_q <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      busy_q    <= is_busy(state_d);
      msg_vld_q <= (state_q == eSTOP) && (state_d == eIDLE);
      err_q     <= is_busy(state_q) && (state_d == eHUNT);
      if (is_busy(state_q) && state_d == eHUNT) err_type_q <= err_cause(state_q);
      if (state_q == eIDLE) idx_q <= '0;
      if (state_q == eH0 && sample) h0_q <= rxd_s;
      if (state_q == eH1 && sample) sr_q[idx_q] <= rxd_s;
      if (state_q == eH1 && state_d == eH0) idx_q <= idx_q + IW'(1);
      if (state_q == eSTOP && state_d == eIDLE) msg_q <= sr_q;
    end
  end

  assign MSG      = msg_q;
  assign MSG_VLD  = msg_vld_q;
  assign ERR      = err_q;
  assign ERR_TYPE = err_type_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_mcht_dec.sv
// Bench for mcht_dec: a single-sampled line (a) and a 4x oversampled, synchronized
// line (b); expected pulses are queued as frames are driven and popped as the DUTs report.
module tb_mcht_dec;
  import mcht_pkg::*;

  logic       CLK_25M = 1'b0;
  logic       RST_N   = 1'b0;
  logic       rxd_a   = 1'b1;
  logic       rxd_b   = 1'b1;
  logic [7:0] msg_a, msg_b;
  logic       vld_a, vld_b, err_a, err_b, busy_a, busy_b;
  logic [1:0] et_a, et_b;

  mcht_dec #(.pMSG_LEN(8), .pHALF_CYC(1), .pSYNC_STG(0)) dut_a (
    .CLK_25M(CLK_25M), .RST_N(RST_N), .RXD(rxd_a), .MSG(msg_a), .MSG_VLD(vld_a),
    .ERR(err_a), .ERR_TYPE(et_a), .BUSY(busy_a));

  mcht_dec #(.pMSG_LEN(8), .pHALF_CYC(4), .pSYNC_STG(2)) dut_b (
    .CLK_25M(CLK_25M), .RST_N(RST_N), .RXD(rxd_b), .MSG(msg_b), .MSG_VLD(vld_b),
    .ERR(err_b), .ERR_TYPE(et_b), .BUSY(busy_b));

  always #20 CLK_25M = ~CLK_25M;

  int cyc = 0;
  always @(posedge CLK_25M) cyc <= cyc + 1;

  typedef struct {
    bit         is_msg;
    logic [7:0] dat;
    logic [1:0] et;
    int         at;
  } exp_t;

  exp_t       qa[$];
  exp_t       qb[$];
  int         total  = 0;
  int         passed = 0;
  int         fails  = 0;
  logic [7:0] last_good [2];
  logic [1:0] last_et [2];
  bit         et_known [2];
  bit         tol [2];
  logic       hv [0:18];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input bit m, input logic [7:0] d, input logic [1:0] et, input int at);
    exp_t e;
    e.is_msg = m;
    e.dat    = d;
    e.et     = et;
    e.at     = at;
    if (s != 0) qb.push_back(e);
    else        qa.push_back(e);
  endtask

  task automatic monitor(input int s, input logic vld, input logic err, input logic [1:0] et,
                         input logic [7:0] msg, input logic [2:0] st);
    exp_t  e;
    int    qs;
    string p;
    p = (s != 0) ? "b" : "a";
    if (!vld && !err) return;
    check({p, "_excl"}, {31'b0, vld & err}, 32'd0);
    qs = (s != 0) ? qb.size() : qa.size();
    if (qs == 0) begin
      check({p, "_unexp_vld"}, {31'b0, vld}, 32'd0);
      if (!tol[s]) check({p, "_unexp_err"}, {31'b0, err}, 32'd0);
      return;
    end
    e = (s != 0) ? qb.pop_front() : qa.pop_front();
    check({p, "_kind_vld"}, {31'b0, vld}, {31'b0, e.is_msg});
    check({p, "_kind_err"}, {31'b0, err}, {31'b0, !e.is_msg});
    if (e.at >= 0) check({p, "_when"}, cyc, e.at);
    if (e.is_msg) begin
      check({p, "_msg"}, {24'b0, msg}, {24'b0, e.dat});
      if (et_known[s]) check({p, "_et_hold"}, {30'b0, et}, {30'b0, last_et[s]});
      last_good[s] = e.dat;
    end else begin
      check({p, "_err_type"}, {30'b0, et}, {30'b0, e.et});
      check({p, "_msg_held"}, {24'b0, msg}, {24'b0, last_good[s]});
      check({p, "_hunt"}, {29'b0, st}, {29'b0, eHUNT});
      last_et[s]  = e.et;
      et_known[s] = 1'b1;
    end
  endtask

  always @(negedge CLK_25M) begin
    if (RST_N) begin
      monitor(0, vld_a, err_a, et_a, msg_a, dut_a.state_q);
      monitor(1, vld_b, err_b, et_b, msg_b, dut_b.state_q);
    end
  end

  task automatic build(input logic [7:0] d, input int bad_cell, input bit bad_pre, input bit bad_stop);
    hv[0] = 1'b0;
    hv[1] = !bad_pre;
    for (int i = 0; i < 8; i++) begin
      hv[2+2*i] = (i == bad_cell) ? 1'b1 : ~d[i];
      hv[3+2*i] = (i == bad_cell) ? 1'b1 : d[i];
    end
    hv[18] = !bad_stop;
  endtask

  task automatic drive_halves(input int s, input int from, input int to);
    for (int j = from; j <= to; j++) begin
      if (s != 0) rxd_b = hv[j];
      else        rxd_a = hv[j];
      repeat ((s != 0) ? 4 : 1) @(posedge CLK_25M);
      #1;
      if (j == 5) check((s != 0) ? "b_busy_mid" : "a_busy_mid",
                        {31'b0, (s != 0) ? busy_b : busy_a}, 32'd1);
    end
  endtask

  task automatic idle(input int s, input int n);
    if (s != 0) rxd_b = 1'b1;
    else        rxd_a = 1'b1;
    repeat (n) @(posedge CLK_25M);
    #1;
  endtask

  // Line a is sampled once per half, so pulse cycles are known exactly from the low cycle c0.
  task automatic send(input int s, input logic [7:0] d, input int bad_cell, input bit bad_pre,
                      input bit bad_stop);
    int c0;
    int last;
    build(d, bad_cell, bad_pre, bad_stop);
    c0 = cyc;
    if (bad_pre) begin
      last = 1;
      push(s, 1'b0, d, eERR_PRE, (s != 0) ? -1 : c0 + 2);
    end else if (bad_cell >= 0) begin
      last = 3 + 2 * bad_cell;
      push(s, 1'b0, d, eERR_CODE, (s != 0) ? -1 : c0 + 4 + 2 * bad_cell);
    end else if (bad_stop) begin
      last = 18;
      push(s, 1'b0, d, eERR_STOP, (s != 0) ? -1 : c0 + 19);
    end else begin
      last = 18;
      push(s, 1'b1, d, 2'b00, (s != 0) ? -1 : c0 + 19);
    end
    drive_halves(s, 0, last);
    if (s != 0) rxd_b = 1'b1;
    else        rxd_a = 1'b1;
  endtask

  task automatic drain(input int s, input int budget);
    int k = 0;
    while ((((s != 0) ? qb.size() : qa.size()) != 0) && k < budget) begin
      @(posedge CLK_25M);
      #1;
      k++;
    end
    check((s != 0) ? "b_drain" : "a_drain", (s != 0) ? qb.size() : qa.size(), 32'd0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      last_good[s] = 8'h00;
      last_et[s]   = 2'b00;
      et_known[s]  = 1'b1;
      tol[s]       = 1'b0;
    end
    RST_N = 1'b0;
    repeat (3) @(posedge CLK_25M);
    #1;
    check("rst_msg",   {24'b0, msg_a}, 32'd0);
    check("rst_vld",   {31'b0, vld_a}, 32'd0);
    check("rst_err",   {31'b0, err_a}, 32'd0);
    check("rst_et",    {30'b0, et_a}, 32'd0);
    check("rst_busy",  {31'b0, busy_a}, 32'd0);
    check("rst_state", {29'b0, dut_a.state_q}, {29'b0, eHUNT});
    check("rst_b_msg", {24'b0, msg_b}, 32'd0);
    RST_N = 1'b1;
    idle(0, 4);

    send(0, 8'hA5, -1, 1'b0, 1'b0);
    idle(0, 3);
    drain(0, 20);

    send(0, 8'h00, -1, 1'b0, 1'b0);
    send(0, 8'hFF, -1, 1'b0, 1'b0);
    idle(0, 3);
    drain(0, 40);

    send(0, 8'hA5, 3, 1'b0, 1'b0);
    idle(0, 3);
    drain(0, 20);
    send(0, 8'hA5, -1, 1'b0, 1'b0);
    idle(0, 3);
    drain(0, 20);

    send(0, 8'h00, -1, 1'b1, 1'b0);
    idle(0, 3);
    drain(0, 20);
    send(0, 8'h5A, -1, 1'b0, 1'b1);
    idle(0, 3);
    drain(0, 20);

    // Reset while the bit-4 first half is low; the frame tail may abort but must never decode.
    tol[0]      = 1'b1;
    et_known[0] = 1'b0;
    build(8'h10, -1, 1'b0, 1'b0);
    drive_halves(0, 0, 9);
    rxd_a = hv[10];
    RST_N = 1'b0;
    repeat (3) @(posedge CLK_25M);
    #1;
    check("mid_rst_msg",   {24'b0, msg_a}, 32'd0);
    check("mid_rst_vld",   {31'b0, vld_a}, 32'd0);
    check("mid_rst_err",   {31'b0, err_a}, 32'd0);
    check("mid_rst_et",    {30'b0, et_a}, 32'd0);
    check("mid_rst_busy",  {31'b0, busy_a}, 32'd0);
    check("mid_rst_state", {29'b0, dut_a.state_q}, {29'b0, eHUNT});
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    RST_N = 1'b1;
    drive_halves(0, 11, 18);
    idle(0, 6);
    tol[0] = 1'b0;
    drain(0, 1);
    send(0, 8'h3C, -1, 1'b0, 1'b0);
    idle(0, 3);
    drain(0, 30);

    rxd_b = 1'b0;
    @(posedge CLK_25M);
    #1;
    idle(1, 10);
    check("b_glitch_busy", {31'b0, busy_b}, 32'd0);
    send(1, 8'h5A, -1, 1'b0, 1'b0);
    idle(1, 12);
    drain(1, 80);
    check("b_end_busy", {31'b0, busy_b}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
